// File: rtl/mojo_serial_block_rx.sv
// mojo_serial_block_rx: assembles 1..MAX_BYTES uart bytes into a held valid/ready block.
// Define MOJO_SERIAL_BLOCK_TIMEOUT_EN to discard partial blocks after TIMEOUT_CYCLES idle cycles.
module mojo_serial_block_rx #(
    parameter int MAX_BYTES = 4,
    parameter bit LSB_FIRST = 1'b0,
    parameter int TIMEOUT_CYCLES = 50000,
    localparam int LB = $clog2(MAX_BYTES + 1),
    localparam int W = MAX_BYTES * 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          new_rx_data,
    input  logic [LB-1:0] block_len,
    output logic [W-1:0]  rx_block,
    output logic [LB-1:0] rx_block_bytes,
    output logic          rx_block_valid,
    input  logic          rx_block_ready,
    output logic          overrun,
    output logic          timeout
);
    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t        state, state_n;
    logic [W-1:0]  blk, blk_n;
    logic [LB-1:0] cnt, cnt_n, len, len_n, req_len;
    logic          ovr_n, take, first, expire;

    function automatic logic [W-1:0] put(input logic [W-1:0] base, input logic [LB-1:0] k,
                                         input logic [7:0] b);
        return LSB_FIRST ? (base | (W'(b) << {k, 3'b000})) : ((base << 8) | W'(b));
    endfunction

    assign req_len = (block_len == '0 || block_len > LB'(MAX_BYTES)) ? LB'(MAX_BYTES) : block_len;
    // A byte in HOLD is only taken when the held block is consumed on the same edge.
    assign take  = new_rx_data && (state != HOLD || rx_block_ready);
    assign first = state != FILL;

`ifdef MOJO_SERIAL_BLOCK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES);
    logic [IW-1:0] idle;
    assign expire = state == FILL && !new_rx_data && idle == IW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle    <= '0;
            timeout <= 1'b0;
        end else begin
            idle    <= (state == FILL && !new_rx_data && !expire) ? idle + IW'(1) : '0;
            timeout <= expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        blk_n   = blk;
        cnt_n   = cnt;
        len_n   = len;
        ovr_n   = state == HOLD && new_rx_data && !rx_block_ready;
        if (state == HOLD && rx_block_ready)
            state_n = IDLE;
        if (take && first) begin
            len_n   = req_len;
            blk_n   = put('0, '0, rx_data);
            cnt_n   = LB'(1);
            state_n = (req_len == LB'(1)) ? HOLD : FILL;
        end else if (take) begin
            blk_n   = put(blk, cnt, rx_data);
            cnt_n   = cnt + LB'(1);
            state_n = (cnt + LB'(1) == len) ? HOLD : FILL;
        end else if (expire) begin
            blk_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            blk     <= '0;
            cnt     <= '0;
            len     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            blk     <= blk_n;
            cnt     <= cnt_n;
            len     <= len_n;
            overrun <= ovr_n;
        end
    end

    assign rx_block       = blk;
    assign rx_block_bytes = cnt;
    assign rx_block_valid = state == HOLD;
endmodule

// File: tb/tb_mojo_serial_block_rx.sv
// tb_mojo_serial_block_rx: directed vector table plus handshake, overrun, timeout and reset sequences.
module tb_mojo_serial_block_rx;
    logic        clk = 1'b0, rst = 1'b0, new_rx_data = 1'b0, ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [2:0]  block_len = '0;
    logic [31:0] blk0, blk1;
    logic [2:0]  cnt0, cnt1;
    logic        v0, v1, ov0, ov1, to0, to1;
    int          n_chk = 0, n_fail = 0, to_pulses = 0, ov_pulses = 0;

    typedef struct {
        logic [2:0]  len;
        int          n;
        logic [31:0] d;
        logic [31:0] e_msb;
        logic [31:0] e_lsb;
        logic [2:0]  e_cnt;
    } vec_t;
    vec_t vt[6];

    mojo_serial_block_rx #(.MAX_BYTES(4), .LSB_FIRST(1'b0), .TIMEOUT_CYCLES(10)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data), .block_len(block_len),
        .rx_block(blk0), .rx_block_bytes(cnt0), .rx_block_valid(v0), .rx_block_ready(ready),
        .overrun(ov0), .timeout(to0));
    mojo_serial_block_rx #(.MAX_BYTES(4), .LSB_FIRST(1'b1), .TIMEOUT_CYCLES(10)) dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data), .block_len(block_len),
        .rx_block(blk1), .rx_block_bytes(cnt1), .rx_block_valid(v1), .rx_block_ready(ready),
        .overrun(ov1), .timeout(to1));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (to0) to_pulses++;
        if (ov0) ov_pulses++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic consume();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("consume_valid", {31'b0, v0}, 32'd0);
    endtask

    initial begin
        vt[0] = '{3'd3, 3, 32'h11223300, 32'h00112233, 32'h00332211, 3'd3};
        vt[1] = '{3'd0, 4, 32'hA1B2C3D4, 32'hA1B2C3D4, 32'hD4C3B2A1, 3'd4};
        vt[2] = '{3'd1, 1, 32'h01000000, 32'h00000001, 32'h00000001, 3'd1};
        vt[3] = '{3'd2, 2, 32'h12340000, 32'h00001234, 32'h00003412, 3'd2};
        vt[4] = '{3'd7, 4, 32'h01020304, 32'h01020304, 32'h04030201, 3'd4};
        vt[5] = '{3'd4, 4, 32'hFF00807F, 32'hFF00807F, 32'h7F8000FF, 3'd4};

        #12;
        chk("reset_block", blk0, 32'd0);
        chk("reset_bytes", {29'b0, cnt0}, 32'd0);
        chk("reset_valid", {30'b0, v0, v1}, 32'd0);
        chk("reset_pulses", {30'b0, ov0, to0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            block_len = vt[i].len;
            for (int j = 0; j < vt[i].n; j++) begin
                send(vt[i].d[31-8*j -: 8]);
                if (j < vt[i].n - 1) chk("early_valid", {31'b0, v0}, 32'd0);
            end
            chk("vec_valid", {30'b0, v0, v1}, 32'd3);
            chk("vec_msb_block", blk0, vt[i].e_msb);
            chk("vec_lsb_block", blk1, vt[i].e_lsb);
            chk("vec_bytes", {29'b0, cnt0}, {29'b0, vt[i].e_cnt});
            @(negedge clk);
            chk("vec_hold_block", blk0, vt[i].e_msb);
            consume();
        end

        // Mid-block length change is ignored.
        block_len = 3'd2;
        send(8'hAA);
        block_len = 3'd4;
        send(8'hBB);
        chk("len_latch_valid", {31'b0, v0}, 32'd1);
        chk("len_latch_block", blk0, 32'h0000AABB);
        consume();

        // Overrun while held.
        ov_pulses = 0;
        block_len = 3'd1;
        send(8'h01);
        send(8'h99);
        chk("overrun_pulse", {31'b0, ov0}, 32'd1);
        chk("overrun_held", blk0, 32'h00000001);
        @(negedge clk);
        chk("overrun_one_cycle", {31'b0, ov0}, 32'd0);
        chk("overrun_count", ov_pulses, 32'd1);
        chk("overrun_still_valid", {31'b0, v0}, 32'd1);
        consume();

        // Simultaneous ready and new byte with length 1.
        ov_pulses = 0;
        send(8'h01);
        ready = 1'b1;
        send(8'h55);
        ready = 1'b0;
        chk("simul_valid", {30'b0, v0, v1}, 32'd3);
        chk("simul_block", blk0, 32'h00000055);
        chk("simul_block_lsb", blk1, 32'h00000055);
        @(negedge clk);
        chk("simul_no_overrun", ov_pulses, 32'd0);
        consume();

        // Partial block followed by a long idle gap.
        to_pulses = 0;
        block_len = 3'd4;
        send(8'h11);
        send(8'h22);
        repeat (14) @(negedge clk);
`ifdef MOJO_SERIAL_BLOCK_TIMEOUT_EN
        chk("timeout_pulses", to_pulses, 32'd1);
        chk("timeout_valid", {31'b0, v0}, 32'd0);
        chk("timeout_cleared", blk0, 32'd0);
        for (int j = 1; j <= 4; j++) send(8'(j));
        chk("after_timeout_block", blk0, 32'h01020304);
        consume();
        to_pulses = 0;
        send(8'hA0);
        send(8'hA1);
        repeat (9) @(negedge clk);
        send(8'hA2);
        send(8'hA3);
        chk("expiry_byte_wins_pulses", to_pulses, 32'd0);
        chk("expiry_byte_wins_block", blk0, 32'hA0A1A2A3);
        consume();
`else
        chk("no_timeout_pulses", to_pulses, 32'd0);
        chk("no_timeout_partial", blk0, 32'h00001122);
        send(8'h33);
        send(8'h44);
        chk("no_timeout_block", blk0, 32'h11223344);
        consume();
`endif

        // Asynchronous reset mid-fill.
        send(8'hDE);
        send(8'hAD);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_block", blk0, 32'd0);
        chk("async_rst_bytes", {29'b0, cnt0}, 32'd0);
        chk("async_rst_valid", {31'b0, v0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(8'h05);
        send(8'h06);
        send(8'h07);
        chk("post_rst_partial", {31'b0, v0}, 32'd0);
        send(8'h08);
        chk("post_rst_block", blk0, 32'h05060708);
        chk("post_rst_block_lsb", blk1, 32'h08070605);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mojo_serial_block_rx.md
Name: mojo_serial_block_rx

Overview:
- Parametrised successor to the fixed-size serial block receiver.
- Assembles a run-time-selectable number of bytes (1..MAX_BYTES) from the UART byte stream into one block.
- Selectable byte order; output uses a valid/ready handshake that holds the block until consumed; dropped bytes are flagged.
- Sits between the UART rx byte interface and the command/packet decoder.

Parameters:
MAX_BYTES, 4, maximum block length in bytes (>=1)
LSB_FIRST, 0, 0: first byte received lands in the most significant used byte; 1: first byte lands in bits [7:0]
TIMEOUT_CYCLES, 50000, inter-byte idle cycles before a partial block is discarded (used only with the optional feature; >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low
rx_data  in  8  received byte
new_rx_data  in  1  one-cycle strobe, rx_data valid
block_len  in  LB=$clog2(MAX_BYTES+1)  requested length; sampled on a block's first byte
rx_block  out  MAX_BYTES*8  assembled block, unused upper bytes zero
rx_block_bytes  out  LB  byte count of the held block
rx_block_valid  out  1  block available
rx_block_ready  in  1  consumer accepts block
overrun  out  1  one-cycle pulse per dropped byte
timeout  out  1  one-cycle pulse when a partial block is discarded

Behaviour:
- Reset (rst low, async): state IDLE; rx_block=0, rx_block_bytes=0, rx_block_valid=0, overrun=0, timeout=0; byte counter 0.
- Length rule: block_len is latched when the first byte is accepted. 0 or values >MAX_BYTES are treated as MAX_BYTES. Changes to block_len mid-block are ignored.
- IDLE:
  - new_rx_data: clear assembly register, store byte, count=1.
  - If latched length is 1, go to HOLD; else go to FILL.
- FILL:
  - Each new_rx_data stores the byte and increments count.
  - When count reaches the length, go to HOLD.
- Byte placement for length N:
  - LSB_FIRST=0: shift-left by 8, insert at [7:0]. The first byte ends at byte N-1; the last byte at [7:0].
  - LSB_FIRST=1: byte k (0-based) written to [8k+7:8k].
  - Bytes >=N are always zero.
- Latency: rx_block_valid rises on the clock edge that samples the last byte's new_rx_data. It is visible the following cycle. rx_block and rx_block_bytes are stable for the whole time valid is high.
- HOLD:
  - Valid high. The handshake completes on an edge with valid&&ready; valid drops and the state returns to IDLE.
  - new_rx_data in HOLD without ready: byte dropped, overrun pulses for one cycle, held block unchanged.
  - Simultaneous ready and new_rx_data in HOLD: handshake completes and the byte is taken as the first byte of the next block (IDLE rules, including length 1 going straight back to HOLD with valid staying high). No overrun.
- Counter width: LB bits; never wraps, because count saturates at the length.
- rst asserted mid-block or mid-HOLD: partial or held data is lost immediately; outputs return to reset values.

Optional Feature:
- Macro: MOJO_SERIAL_BLOCK_TIMEOUT_EN
- Defined:
  - An idle counter runs in FILL. It clears on every new_rx_data.
  - If it reaches TIMEOUT_CYCLES with no new byte, the partial block is discarded (count=0, assembly register cleared), timeout pulses for one cycle, and the state goes to IDLE.
  - A byte arriving on the expiry cycle wins: it is accepted and there is no timeout.
  - The counter is inactive in IDLE and HOLD.
- Not defined: no counter is built, timeout is tied 0, and a partial block waits indefinitely.

Test Plan:
- MAX_BYTES=4, LSB_FIRST=0, block_len=3, bytes 0x11,0x22,0x33 -> rx_block=0x00112233, rx_block_bytes=3, valid the cycle after the 0x33 strobe.
- LSB_FIRST=1, block_len=0, bytes 0xA1,0xB2,0xC3,0xD4 -> rx_block=0xD4C3B2A1, rx_block_bytes=4.
- ready=0, block 0x01 (len 1) held, then byte 0x99 -> overrun pulses once, rx_block stays 0x00000001; then ready=1 -> valid drops.
- Held block, ready=1 and new_rx_data=0x55 in the same cycle with block_len=1 -> first block consumed, next cycle valid=1 with rx_block=0x00000055, overrun never pulses.
- With macro, TIMEOUT_CYCLES=10, block_len=4, 2 bytes then 10 idle cycles -> timeout pulses once, valid stays 0; next 4 bytes 0x01..0x04 -> rx_block=0x01020304.
- rst low asynchronously mid-FILL after 2 bytes -> all outputs 0 without waiting for a clock edge; after release, a fresh 4-byte block assembles correctly.
